uart_core: RTL and testbench
============================

# uart_core

Parametrised full-duplex UART with a built-in baud generator, 16x-oversampled receiver, transmitter and two internal first-word-fall-through FIFOs. Data width, stop length and FIFO depth are set at elaboration; parity is selected at run time. Received bytes carry per-word parity and framing error flags, and receive overrun is reported. It needs no vendor FIFO IP and sits between a bus-register front end and the serial pins.

## Interface
- DBITS, 8: data bits per frame (5..9)
- SB_TICK, 16: stop-bit length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW
- DVSR_BITS, 11: width of the divisor input

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- dvsr  in  DVSR_BITS  tick period minus 1, in clk cycles
- parity_en  in  1  adds a parity bit to the frame
- parity_odd  in  1  1 = odd parity, 0 = even parity
- rx  in  1  serial input (asynchronous)
- rd_uart  in  1  pop the head of the RX FIFO
- r_data  out  DBITS  head of the RX FIFO
- r_perr  out  1  parity error flag of the head word
- r_ferr  out  1  framing error flag of the head word
- rx_empty  out  1  RX FIFO empty
- overrun  out  1  sticky: a received word was dropped
- clr_overrun  in  1  clears overrun
- tx  out  1  serial output
- w_data  in  DBITS  word to transmit
- wr_uart  in  1  push w_data into the TX FIFO
- tx_full  out  1  TX FIFO full
- tx_busy  out  1  transmitter not idle

## Operation
- **Reset values:**
  - tx = 1, tx_busy = 0, tx_full = 0, rx_empty = 1, overrun = 0.
  - r_data, r_perr and r_ferr = 0.
  - Both FSMs are in IDLE and the baud counter = 0.
- **Baud generator:**
  - The counter runs 0..dvsr and wraps to 0.
  - tick is high for one cycle when counter == dvsr.
  - dvsr = 0 gives a tick every cycle.
- **RX synchroniser:** rx passes through 2 flops, both reset to 1. All RX logic uses the synchronised value.
- **RX FSM states:** IDLE, START, DATA, PARITY, STOP. s is the tick counter and n the bit counter.
  - IDLE: on a low input, go to START with s = 0. parity_en and parity_odd are latched here.
  - START: on the tick where s == 7, a low input goes to DATA with s = 0 and n = 0. A high input returns to IDLE (glitch rejected, nothing pushed).
  - DATA: on the tick where s == 15, shift the input in LSB first.
    - After DBITS bits, go to PARITY if parity is latched on, else to STOP.
  - PARITY: sample at s == 15. perr = XOR(data, parity bit, latched odd) mismatch.
  - STOP: sample at s == SB_TICK-1. ferr = ~input. Push {ferr, perr, data} and go to IDLE.
  - perr = 0 when parity is disabled.
- **Overrun:** a push into a full RX FIFO is dropped and sets overrun. clr_overrun clears it; if a set and a clear land in the same cycle, set wins.
- **TX FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If the TX FIFO is not empty, load the head, pop it in the same cycle, latch the parity controls, and go to START.
  - START: tx = 0 for 16 ticks.
  - DATA: each bit lasts 16 ticks, LSB first.
  - PARITY: only if enabled, 16 ticks.
  - STOP: tx = 1 for SB_TICK ticks, then back to IDLE.
  - tx_busy = (state != IDLE).
- **FIFOs (first-word fall-through):**
  - Head data is valid whenever the FIFO is not empty.
  - A write when full is ignored (TX); an RX push when full counts as overrun.
  - A read when empty is ignored.
  - A simultaneous read and write when full performs both; the count is unchanged.
  - A simultaneous read and write when empty performs the write only.
  - Pointers wrap modulo depth. full and empty are derived from an extra pointer MSB.
- **Reset mid-frame:** both FSMs return to IDLE and both FIFOs empty. tx = 1 in the cycle after reset asserts.

## Timing
- FIFO flags are registered. wr_uart at edge k makes rx_empty/tx_full reflect the new count from edge k+1.
- The RX push lands in the FIFO at the STOP sample tick. rx_empty falls one cycle later.
- TX starts 1 cycle after the TX FIFO becomes non-empty; tx goes low in that cycle.
- Frame length = (16·(1 + DBITS + parity) + SB_TICK) ticks.
- The TX FIFO is popped at frame start, not at frame end. Back-to-back words therefore have no idle gap beyond 1 cycle.

## Configuration
- Macro: UART_LOOPBACK_EN.
  - **Defined:** an extra input port loopback (1 bit, after clr_overrun).
    - When loopback = 1, the RX synchroniser input is the internal TX serial bit and the tx pin is held at 1.
    - When loopback = 0, behaviour is normal.
  - **Undefined:** the port is absent and the receiver always uses the rx pin.

## Structure
- Package uart_pkg holds:
  - the rx_state_t and tx_state_t enums,
  - the tick-count constants (START_MID = 7, BIT_TICKS = 16),
  - a parity function parity_calc(data, odd).
- Sub-module uart_fifo (parameters W and AW, first-word fall-through) is instantiated twice:
  - RX with W = DBITS+2,
  - TX with W = DBITS.
- The baud generator, RX FSM and TX FSM are inline in uart_core.

## Test plan
- dvsr = 3, no parity, write 0xA5:
  - tx = 0 for 64 cycles, then 1,0,1,0,0,1,0,1 at 64 cycles each, then 1 for 64 cycles.
  - tx_busy is high throughout.
- UART_LOOPBACK_EN defined, loopback = 1, parity_en = 1, parity_odd = 1, write 0x3C, 0xFF, 0x00:
  - RX FIFO returns the same three words in order, with r_perr = 0 and r_ferr = 0.
- External RX frame 0x55 with even parity configured, driving a wrong parity bit:
  - the word reads 0x55 with r_perr = 1.
- External RX frame 0x81 with the stop bit driven 0:
  - r_ferr = 1, and the next correct frame reads r_ferr = 0.
- FIFO_AW = 4, 17 frames received without any rd_uart:
  - overrun = 1, and exactly 16 words are readable (the first 16).
  - clr_overrun returns overrun to 0.
- Pulse rx low for 4 ticks only, then assert reset mid-way through a TX frame:
  - no RX word is pushed.
  - After reset, tx = 1, tx_busy = 0, tx_full = 0 and rx_empty = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types, tick-count constants and the parity helper.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   localparam int START_MID = 7;
   localparam int BIT_TICKS = 16;

   // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
   function automatic logic parity_calc(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO; full/empty come from an extra pointer MSB.
module uart_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_i,
   input  logic [W-1:0] wdata_i,
   input  logic         rd_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0] mem_q [0:(1<<AW)-1];
   logic [AW:0]  wptr_q, wptr_d;
   logic [AW:0]  rptr_q, rptr_d;
   logic         wr_en, rd_en;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle.
   assign rd_en   = rd_i & ~empty_o;
   assign wr_en   = wr_i & (~full_o | rd_en);

   assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
   assign wptr_d  = wr_en ? wptr_q + (AW+1)'(1) : wptr_q;
   assign rptr_d  = rd_en ? rptr_q + (AW+1)'(1) : rptr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with baud generator, 16x-oversampled RX, TX and two FWFT FIFOs.
// Defining UART_LOOPBACK_EN adds a loopback input that feeds the TX bit into the receiver.
module uart_core
   import uart_pkg::*;
#(
   parameter int DBITS     = 8,
   parameter int SB_TICK   = 16,
   parameter int FIFO_AW   = 4,
   parameter int DVSR_BITS = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DVSR_BITS-1:0] dvsr,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 rx,
   input  logic                 rd_uart,
   output logic [DBITS-1:0]     r_data,
   output logic                 r_perr,
   output logic                 r_ferr,
   output logic                 rx_empty,
   output logic                 overrun,
   input  logic                 clr_overrun,
`ifdef UART_LOOPBACK_EN
   input  logic                 loopback,
`endif
   output logic                 tx,
   input  logic [DBITS-1:0]     w_data,
   input  logic                 wr_uart,
   output logic                 tx_full,
   output logic                 tx_busy
);

   // state  | meaning (shared by the RX and TX machines)
   // IDLE   | line idle; RX waits for a low input, TX waits for FIFO data
   // START  | start bit (RX checks its middle at tick 7)
   // DATA   | DBITS data bits, LSB first, 16 ticks each
   // PARITY | optional parity bit, 16 ticks
   // STOP   | stop bit(s), SB_TICK ticks

   localparam int SW = 6;
   localparam int NW = 4;

   logic [DVSR_BITS-1:0] baud_q, baud_d;
   logic                 tick;
   logic                 rx_src, sync1_q, sync2_q, rx_in;
   logic                 tx_q, tx_d;

   rx_state_t            rx_st_q, rx_st_d;
   logic [SW-1:0]        rx_s_q, rx_s_d;
   logic [NW-1:0]        rx_n_q, rx_n_d;
   logic [DBITS-1:0]     rx_b_q, rx_b_d;
   logic                 rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d, rx_perr_q, rx_perr_d;
   logic                 rx_push, rx_full, ovr_q, ovr_d;
   logic [DBITS+1:0]     rx_word, rx_head;

   tx_state_t            tx_st_q, tx_st_d;
   logic [SW-1:0]        tx_s_q, tx_s_d;
   logic [NW-1:0]        tx_n_q, tx_n_d;
   logic [DBITS-1:0]     tx_b_q, tx_b_d, tx_head;
   logic                 tx_pen_q, tx_pen_d, tx_pbit_q, tx_pbit_d;
   logic                 tx_pop, tx_empty;

   assign tick   = (baud_q == dvsr);
   assign baud_d = tick ? '0 : baud_q + DVSR_BITS'(1);

`ifdef UART_LOOPBACK_EN
   assign rx_src = loopback ? tx_q : rx;
   assign tx     = loopback ? 1'b1 : tx_q;
`else
   assign rx_src = rx;
   assign tx     = tx_q;
`endif
   assign rx_in  = sync2_q;

   always_comb begin
      rx_st_d   = rx_st_q;
      rx_s_d    = rx_s_q;
      rx_n_d    = rx_n_q;
      rx_b_d    = rx_b_q;
      rx_pen_d  = rx_pen_q;
      rx_podd_d = rx_podd_q;
      rx_perr_d = rx_perr_q;
      rx_push   = 1'b0;
      case (rx_st_q)
         RX_IDLE: begin
            if (!rx_in) begin
               rx_st_d   = RX_START;
               rx_s_d    = '0;
               rx_pen_d  = parity_en;
               rx_podd_d = parity_odd;
            end
         end
         RX_START: begin
            if (tick) begin
               if (rx_s_q == SW'(START_MID)) begin
                  rx_s_d    = '0;
                  rx_n_d    = '0;
                  rx_perr_d = 1'b0;
                  rx_st_d   = rx_in ? RX_IDLE : RX_DATA;
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               if (rx_s_q == SW'(BIT_TICKS - 1)) begin
                  rx_s_d = '0;
                  rx_b_d = {rx_in, rx_b_q[DBITS-1:1]};
                  if (rx_n_q == NW'(DBITS - 1)) begin
                     rx_st_d = rx_pen_q ? RX_PARITY : RX_STOP;
                  end else begin
                     rx_n_d = rx_n_q + NW'(1);
                  end
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         RX_PARITY: begin
            if (tick) begin
               if (rx_s_q == SW'(BIT_TICKS - 1)) begin
                  rx_s_d    = '0;
                  rx_perr_d = (rx_in != parity_calc(9'(rx_b_q), rx_podd_q));
                  rx_st_d   = RX_STOP;
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (rx_s_q == SW'(SB_TICK - 1)) begin
                  rx_push = 1'b1;
                  rx_st_d = RX_IDLE;
               end else begin
                  rx_s_d = rx_s_q + SW'(1);
               end
            end
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

   assign rx_word = {~rx_in, rx_perr_q, rx_b_q};
   // A push into a full FIFO is only lost when no pop frees a slot in the same cycle.
   assign ovr_d   = (rx_push & rx_full & ~rd_uart) | (ovr_q & ~clr_overrun);

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_s_d    = tx_s_q;
      tx_n_d    = tx_n_q;
      tx_b_d    = tx_b_q;
      tx_pen_d  = tx_pen_q;
      tx_pbit_d = tx_pbit_q;
      tx_pop    = 1'b0;
      case (tx_st_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop    = 1'b1;
               tx_b_d    = tx_head;
               tx_pen_d  = parity_en;
               tx_pbit_d = parity_calc(9'(tx_head), parity_odd);
               tx_s_d    = '0;
               tx_st_d   = TX_START;
            end
         end
         TX_START: begin
            if (tick) begin
               if (tx_s_q == SW'(BIT_TICKS - 1)) begin
                  tx_s_d  = '0;
                  tx_n_d  = '0;
                  tx_st_d = TX_DATA;
               end else begin
                  tx_s_d = tx_s_q + SW'(1);
               end
            end
         end
         TX_DATA: begin
            if (tick) begin
               if (tx_s_q == SW'(BIT_TICKS - 1)) begin
                  tx_s_d = '0;
                  tx_b_d = tx_b_q >> 1;
                  if (tx_n_q == NW'(DBITS - 1)) begin
                     tx_st_d = tx_pen_q ? TX_PARITY : TX_STOP;
                  end else begin
                     tx_n_d = tx_n_q + NW'(1);
                  end
               end else begin
                  tx_s_d = tx_s_q + SW'(1);
               end
            end
         end
         TX_PARITY: begin
            if (tick) begin
               if (tx_s_q == SW'(BIT_TICKS - 1)) begin
                  tx_s_d  = '0;
                  tx_st_d = TX_STOP;
               end else begin
                  tx_s_d = tx_s_q + SW'(1);
               end
            end
         end
         TX_STOP: begin
            if (tick) begin
               if (tx_s_q == SW'(SB_TICK - 1)) begin
                  tx_st_d = TX_IDLE;
               end else begin
                  tx_s_d = tx_s_q + SW'(1);
               end
            end
         end
         default: tx_st_d = TX_IDLE;
      endcase

      // The serial bit is registered from the next state so tx is glitch-free.
      case (tx_st_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = tx_b_d[0];
         TX_PARITY: tx_d = tx_pbit_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_q    <= '0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_st_q   <= RX_IDLE;
         rx_s_q    <= '0;
         rx_n_q    <= '0;
         rx_b_q    <= '0;
         rx_pen_q  <= 1'b0;
         rx_podd_q <= 1'b0;
         rx_perr_q <= 1'b0;
         ovr_q     <= 1'b0;
         tx_st_q   <= TX_IDLE;
         tx_s_q    <= '0;
         tx_n_q    <= '0;
         tx_b_q    <= '0;
         tx_pen_q  <= 1'b0;
         tx_pbit_q <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         baud_q    <= baud_d;
         sync1_q   <= rx_src;
         sync2_q   <= sync1_q;
         rx_st_q   <= rx_st_d;
         rx_s_q    <= rx_s_d;
         rx_n_q    <= rx_n_d;
         rx_b_q    <= rx_b_d;
         rx_pen_q  <= rx_pen_d;
         rx_podd_q <= rx_podd_d;
         rx_perr_q <= rx_perr_d;
         ovr_q     <= ovr_d;
         tx_st_q   <= tx_st_d;
         tx_s_q    <= tx_s_d;
         tx_n_q    <= tx_n_d;
         tx_b_q    <= tx_b_d;
         tx_pen_q  <= tx_pen_d;
         tx_pbit_q <= tx_pbit_d;
         tx_q      <= tx_d;
      end
   end

   uart_fifo #(.W(DBITS + 2), .AW(FIFO_AW)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (rx_push),
      .wdata_i (rx_word),
      .rd_i    (rd_uart),
      .rdata_o (rx_head),
      .full_o  (rx_full),
      .empty_o (rx_empty)
   );

   uart_fifo #(.W(DBITS), .AW(FIFO_AW)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (wr_uart),
      .wdata_i (w_data),
      .rd_i    (tx_pop),
      .rdata_o (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   assign r_data  = rx_head[DBITS-1:0];
   assign r_perr  = rx_head[DBITS];
   assign r_ferr  = rx_head[DBITS+1];
   assign overrun = ovr_q;
   assign tx_busy = (tx_st_q != TX_IDLE);

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core (dvsr = 3, so one bit = 64 clk cycles).
`timescale 1ns/1ps
module tb_uart_core;

   localparam int BIT = 64;

   logic        clk = 1'b0;
   logic        reset, parity_en, parity_odd, rx, rd_uart, clr_overrun, loopback, wr_uart;
   logic [10:0] dvsr;
   logic [7:0]  r_data, w_data;
   logic        r_perr, r_ferr, rx_empty, overrun, tx, tx_full, tx_busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      logic       pe, odd, bad_par, bad_stop;
      logic [7:0] exp_d;
      logic       exp_perr, exp_ferr;
   } rx_vec_t;

   rx_vec_t     vecs [7];
   logic [7:0]  q [$];
   logic [7:0]  words [4];
   logic [7:0]  dd, a5, rd;
   logic        pb, sb, s0, pe_r, odd_r, bp_r, bs_r;
   int          w, bad, bb, n;

   uart_core dut (
      .clk         (clk),
      .reset       (reset),
      .dvsr        (dvsr),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .rx          (rx),
      .rd_uart     (rd_uart),
      .r_data      (r_data),
      .r_perr      (r_perr),
      .r_ferr      (r_ferr),
      .rx_empty    (rx_empty),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
`ifdef UART_LOOPBACK_EN
      .loopback    (loopback),
`endif
      .tx          (tx),
      .w_data      (w_data),
      .wr_uart     (wr_uart),
      .tx_full     (tx_full),
      .tx_busy     (tx_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference parity bit: makes the ones count even, or odd when odd = 1.
   function automatic logic ref_pbit(input logic [7:0] d, input logic odd);
      int ones = $countones(d);
      return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   task automatic tick_n(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic pop();
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] d);
      w_data  = d;
      wr_uart = 1'b1;
      @(negedge clk);
      wr_uart = 1'b0;
   endtask

   task automatic wait_tx_idle();
      int k = 0;
      while (tx_busy && k < 4000) begin @(negedge clk); k++; end
      check("tx_idle", tx_busy, 0);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic pe, input logic odd,
                          input logic bad_par, input logic bad_stop);
      parity_en  = pe;
      parity_odd = odd;
      rx = 1'b0;
      tick_n(BIT);
      for (int i = 0; i < 8; i++) begin rx = d[i]; tick_n(BIT); end
      if (pe) begin rx = ref_pbit(d, odd) ^ bad_par; tick_n(BIT); end
      if (bad_stop) begin
         // Low across the stop sample point, then high well before a false start would be confirmed.
         rx = 1'b0; tick_n(48);
         rx = 1'b1; tick_n(BIT + 16);
      end else begin
         rx = 1'b1; tick_n(BIT);
      end
      tick_n(BIT);
   endtask

   task automatic read_check(input string name, input logic [7:0] ed, input logic ep, input logic ef);
      int k = 0;
      while (rx_empty && k < 3000) begin @(negedge clk); k++; end
      check({name, "_avail"}, !rx_empty, 1);
      check({name, "_data"}, r_data, ed);
      check({name, "_perr"}, r_perr, ep);
      check({name, "_ferr"}, r_ferr, ef);
      pop();
   endtask

   // Decodes one frame from the tx pin by sampling the middle of each bit.
   task automatic decode_tx(input logic pe, output logic [7:0] d, output logic p,
                            output logic st, output logic sp);
      int k = 0;
      while (tx !== 1'b0 && k < 3000) begin @(negedge clk); k++; end
      tick_n(BIT / 2);
      st = tx;
      for (int i = 0; i < 8; i++) begin tick_n(BIT); d[i] = tx; end
      p = 1'b0;
      if (pe) begin tick_n(BIT); p = tx; end
      tick_n(BIT);
      sp = tx;
   endtask

   initial begin
      reset = 1'b1; rx = 1'b1; dvsr = 11'd3; parity_en = 1'b0; parity_odd = 1'b0;
      rd_uart = 1'b0; clr_overrun = 1'b0; loopback = 1'b0; wr_uart = 1'b0; w_data = 8'h00;

      vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0};
      vecs[1] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
      vecs[3] = '{8'hA7, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA7, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h6E, 1'b1, 1'b1, 1'b1, 1'b1, 8'h6E, 1'b1, 1'b1};

      tick_n(2);
      check("rst_tx", tx, 1);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_tx_full", tx_full, 0);
      check("rst_rx_empty", rx_empty, 1);
      check("rst_overrun", overrun, 0);
      check("rst_r_data", r_data, 0);
      check("rst_r_perr", r_perr, 0);
      check("rst_r_ferr", r_ferr, 0);
      reset = 1'b0;
      tick_n(5);

      // Directed 0xA5 frame, no parity.
      parity_en = 1'b0;
      a5 = 8'hA5;
      push_tx(a5);
      n = 0;
      while (tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      check("a5_start_seen", tx, 0);
      w = 0; bb = 0;
      while (tx === 1'b0 && w < 100) begin
         if (!tx_busy) bb++;
         w++;
         @(negedge clk);
      end
      check("a5_start_len", (w >= 61 && w <= 64), 1);
      for (int i = 0; i < 8; i++) begin
         bad = 0;
         for (int j = 0; j < BIT; j++) begin
            if (tx !== a5[i]) bad++;
            if (!tx_busy) bb++;
            @(negedge clk);
         end
         check("a5_bit", bad, 0);
      end
      bad = 0;
      for (int j = 0; j < BIT; j++) begin
         if (tx !== 1'b1) bad++;
         if (!tx_busy) bb++;
         @(negedge clk);
      end
      check("a5_stop", bad, 0);
      check("a5_busy", bb, 0);
      check("a5_idle_after", tx_busy, 0);

      // Random TX bursts decoded from the pin.
      for (int b = 0; b < 2; b++) begin
         pe_r  = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         odd_r = 1'($urandom_range(0, 1));
         parity_en = pe_r; parity_odd = odd_r;
         for (int i = 0; i < 4; i++) begin
            words[i] = 8'($urandom);
            push_tx(words[i]);
         end
         for (int i = 0; i < 4; i++) begin
            decode_tx(pe_r, dd, pb, s0, sb);
            check("txr_start", s0, 0);
            check("txr_data", dd, words[i]);
            if (pe_r) check("txr_parity", pb, ref_pbit(words[i], odd_r));
            check("txr_stop", sb, 1);
         end
         wait_tx_idle();
      end

      // Directed RX vectors.
      for (int i = 0; i < 7; i++) begin
         send_rx(vecs[i].d, vecs[i].pe, vecs[i].odd, vecs[i].bad_par, vecs[i].bad_stop);
         read_check("rxv", vecs[i].exp_d, vecs[i].exp_perr, vecs[i].exp_ferr);
      end
      check("rxv_drained", rx_empty, 1);

      // Random RX frames against the reference rules.
      for (int i = 0; i < 8; i++) begin
         rd    = 8'($urandom);
         pe_r  = 1'($urandom_range(0, 1));
         odd_r = 1'($urandom_range(0, 1));
         bp_r  = 1'($urandom_range(0, 1));
         bs_r  = ($urandom_range(0, 3) == 0);
         send_rx(rd, pe_r, odd_r, bp_r, bs_r);
         read_check("rxr", rd, pe_r & bp_r, bs_r);
      end

`ifdef UART_LOOPBACK_EN
      loopback = 1'b1; parity_en = 1'b1; parity_odd = 1'b1;
      words[0] = 8'h3C; words[1] = 8'hFF; words[2] = 8'h00;
      for (int i = 0; i < 3; i++) push_tx(words[i]);
      tick_n(200);
      check("lb_tx_pin", tx, 1);
      for (int i = 0; i < 3; i++) read_check("lb", words[i], 1'b0, 1'b0);
      wait_tx_idle();
      loopback = 1'b0;
      tick_n(10);
`endif

      // Overrun: 17 frames, depth 16, nothing read.
      q.delete();
      for (int i = 0; i < 17; i++) begin
         rd = 8'($urandom);
         q.push_back(rd);
         send_rx(rd, 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 15) check("ovr_before_full", overrun, 0);
      end
      check("ovr_set", overrun, 1);
      for (int i = 0; i < 16; i++) read_check("ovr_word", q[i], 1'b0, 1'b0);
      check("ovr_only16", rx_empty, 1);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      check("ovr_cleared", overrun, 0);

      // Glitch rejection, TX FIFO full, then reset mid-frame.
      rx = 1'b0; tick_n(16);
      rx = 1'b1; tick_n(3 * BIT);
      check("glitch_no_push", rx_empty, 1);
      parity_en = 1'b0;
      wr_uart = 1'b1;
      for (int i = 0; i < 17; i++) begin
         w_data = 8'(i + 1);
         @(negedge clk);
      end
      wr_uart = 1'b0;
      check("tx_full_at_16", tx_full, 1);
      tick_n(300);
      check("mid_frame_busy", tx_busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("rst2_tx", tx, 1);
      check("rst2_tx_busy", tx_busy, 0);
      check("rst2_tx_full", tx_full, 0);
      check("rst2_rx_empty", rx_empty, 1);
      reset = 1'b0;
      tick_n(BIT);
      check("post_rst_tx", tx, 1);
      check("post_rst_busy", tx_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
